// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues word reads to instruction memory,
// buffers returned words in a small FIFO and presents {pc, instr} to decode.
// A redirect restarts fetch at a new target and squashes everything still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q;
  logic [31:0]   out_pc;
  logic [31:0]   redir_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   fifo_mem [DEPTH];
  logic [CW:0]   occupancy;
  logic          issue;
  logic          rsp_keep;
  logic          pop;

  // Low two bits of the redirect target are meaningless for word fetch
  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

  // Credit: a request may only go out if its response is guaranteed a FIFO slot
  assign occupancy      = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = rst_n && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign issue          = imem_req_valid && imem_req_ready;

  // Responses owed to a squashed path are discarded; so is anything arriving during a flush
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign if_valid = (count != '0);
  assign pop      = if_valid && if_ready && !redirect_valid;
  assign if_instr = if_valid ? fifo_mem[rd_ptr] : NOP;
  assign if_pc    = out_pc;

  // Fetch PC: redirect wins, otherwise advance on every accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redir_pc;
    end else if (issue) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // PC of the FIFO head, advances as decode consumes instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc <= RESET_PC;
    end else if (redirect_valid) begin
      out_pc <= redir_pc;
    end else if (pop) begin
      out_pc <= out_pc + 32'd4;
    end
  end

  // Outstanding memory reads; no request issues during a redirect so one expression covers both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(imem_rsp_valid);
    end
  end

  // Stale-response counter: on redirect every read still outstanding after this cycle is stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= inflight - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // FIFO pointers and occupancy, cleared by a redirect flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (rsp_keep) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(rsp_keep) - CW'(pop);
    end
  end

  // FIFO storage; contents are only observed when count says they are valid
  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      fifo_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule
